mc_cr_scheduler: RTL
====================

Name: mc_cr_scheduler

Overview:
- Sequences the chroma motion-compensation datapath for one inter macroblock.
- Accepts one MB command (MB position plus chroma motion vector) and issues eight 4x4 chroma block jobs to the datapath: Cb blocks 0-3, then Cr blocks 0-3.
- Tracks outstanding jobs with a credit counter and pulses mb_done once all eight blocks report completion.
- Sits between the MB-level inter controller and the chroma interpolation datapath.

Parameters:
MBW, 7, width of mb_x / mb_y (MB units)
MVW, 12, width of signed mvx / mvy (1/8 chroma-sample units)
CW, 12, width of signed ref_x / ref_y (chroma sample units)
MAX_OUT, 2, maximum issued-but-not-completed block jobs (1..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mb_valid  in  1  MB command valid
mb_ready  out  1  scheduler can accept an MB command
mb_x  in  MBW  MB column
mb_y  in  MBW  MB row
mvx  in  MVW  signed chroma MV x, 1/8 sample
mvy  in  MVW  signed chroma MV y, 1/8 sample
blk_valid  out  1  block job valid
blk_ready  in  1  datapath accepts job
blk_plane  out  1  0=Cb, 1=Cr
blk_idx  out  2  4x4 block index in the 8x8 chroma MB, raster order
ref_x  out  CW  signed integer top-left x of the reference patch
ref_y  out  CW  signed integer top-left y of the reference patch
frac_x  out  3  fractional x (dx)
frac_y  out  3  fractional y (dy)
blk_done  in  1  one-cycle pulse: one block's samples written
mb_done  out  1  one-cycle pulse: all 8 blocks complete
busy  out  1  state != IDLE

Behaviour:
- Reset (sync): state=IDLE; issue_cnt, done_cnt and outstanding all 0; captured registers 0. Outputs: mb_ready=1, blk_valid=0, mb_done=0, busy=0, all blk_* fields 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - mb_ready=1.
  - On mb_valid&&mb_ready: capture mb_x, mb_y, mvx, mvy; clear counters; go to ISSUE.
  - blk_done in IDLE is ignored.
- ISSUE
  - blk_valid = (outstanding < MAX_OUT).
  - Handshake = blk_valid&&blk_ready. On handshake, issue_cnt++ and outstanding++.
  - The handshake with issue_cnt==7 moves the FSM to DRAIN.
  - blk_valid, once high, stays high with stable fields until the handshake. Outstanding only rises on a handshake, so this holds by construction.
- DRAIN
  - blk_valid=0.
  - Go to DONE in the cycle where done_cnt, including that cycle's blk_done, reaches 8.
- DONE: mb_done=1 for exactly one cycle, then IDLE. mb_ready is 0 in DONE and returns to 1 in IDLE.
- blk_done, in every state except IDLE:
  - If outstanding>0: done_cnt++ and outstanding--.
  - If outstanding==0: ignored (protocol error, no state change).
  - Handshake and blk_done in the same cycle: outstanding is unchanged; issue_cnt and done_cnt both increment.
- Job fields, derived from issue_cnt (registered values, stable while blk_valid is high):
  - blk_plane = issue_cnt[2]; blk_idx = issue_cnt[1:0].
  - bx = mb_x*8 + blk_idx[0]*4; by = mb_y*8 + blk_idx[1]*4.
  - ref_x = bx + (mvx >>> 3); ref_y = by + (mvy >>> 3). Arithmetic shift; sign-extended to CW bits and truncated to CW bits.
  - frac_x = mvx[2:0]; frac_y = mvy[2:0].
  - No clamping to picture bounds; edge padding belongs to the reference fetch.
  - Cb and Cr jobs use identical ref/frac values.
- Latency:
  - blk_valid rises the cycle after the MB handshake.
  - Minimum MB time with blk_ready=1 and a blk_done the cycle after each issue: 8 issue cycles + drain + DONE.
- Reset mid-operation returns to the reset state immediately. Late blk_done pulses arriving afterwards land in IDLE and are ignored.
- Back-to-back MBs: the next mb handshake is possible the cycle after DONE.

Decomposition:
- Package mc_cr_pkg holds:
  - state_t enum {IDLE, ISSUE, DRAIN, DONE};
  - NUM_BLK=8, BLK_SHIFT=2, MB_C_SHIFT=3;
  - PLANE_CB=0, PLANE_CR=1.
- Sub-module mc_cr_addr_gen (combinational): maps mb_x, mb_y, mv and blk index to ref_x, ref_y, frac_x, frac_y. It is reusable by the reference fetch unit.

Test Plan:
- Basic addressing: mb_x=2, mb_y=1, mvx=-11, mvy=6, blk_ready=1, MAX_OUT=2.
  - Cb blk0 -> ref_x=14, ref_y=8, frac_x=5, frac_y=6.
  - Cb blk3 -> ref_x=18, ref_y=12.
  - Cr blk0 repeats ref_x=14, ref_y=8.
  - Exactly 8 jobs in order Cb0..Cb3, Cr0..Cr3.
- Credit stall: MAX_OUT=2, blk_done withheld -> blk_valid drops after 2 jobs. A blk_done pulse re-raises blk_valid in the cycle after the pulse, so one more job issues.
- Simultaneous events: handshake and blk_done in the same cycle -> outstanding unchanged. After 8 dones, mb_done is a single pulse, then mb_ready=1.
- Backpressure: blk_ready=0 for 5 cycles while blk_valid=1 -> blk_valid and all fields are held stable; exactly one job is issued on release.
- Spurious done: blk_done with outstanding=0, and blk_done in IDLE -> no counter change; mb_done still fires only after 8 valid dones.
- Mid-MB reset: assert reset after job 3 -> the next cycle gives busy=0, mb_ready=1, blk_valid=0. A following MB runs a full 8-job sequence from Cb0.

Source files
------------

// File: rtl/mc_cr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_cr_pkg
//  Description : Shared types and constants for the chroma MC scheduler and
//                its address generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_cr_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Eight 4x4 chroma jobs per MB (4 Cb + 4 Cr)
  localparam int NUM_BLK    = 8;
  // 4x4 block offset inside the chroma MB
  localparam int BLK_SHIFT  = 2;
  // 8x8 chroma MB size; also the 1/8-sample MV fraction width
  localparam int MB_C_SHIFT = 3;

  localparam logic PLANE_CB = 1'b0;
  localparam logic PLANE_CR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mc_cr_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mc_cr_addr_gen
//  Description : Combinational mapping of MB position, chroma MV and 4x4 block
//                index to the integer reference patch origin and the 1/8
//                sample fractional phase. No picture-bound clamping here;
//                edge padding is done by the reference fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_cr_addr_gen
  import mc_cr_pkg::*;
#(
  parameter int MBW = 7,
  parameter int MVW = 12,
  parameter int CW  = 12
) (
  input  logic        [MBW-1:0] mb_x,
  input  logic        [MBW-1:0] mb_y,
  input  logic signed [MVW-1:0] mvx,
  input  logic signed [MVW-1:0] mvy,
  input  logic        [1:0]     blk_idx,
  output logic signed [CW-1:0]  ref_x,
  output logic signed [CW-1:0]  ref_y,
  output logic        [2:0]     frac_x,
  output logic        [2:0]     frac_y
);

  logic        [CW-1:0]  w_bx;
  logic        [CW-1:0]  w_by;
  logic signed [MVW-1:0] w_mvx_int;
  logic signed [MVW-1:0] w_mvy_int;

  // Block origin plus floor(mv/8); sums wrap to CW bits by design
  always_comb begin
    w_bx      = (CW'(mb_x) << MB_C_SHIFT) + (CW'(blk_idx[0]) << BLK_SHIFT);
    w_by      = (CW'(mb_y) << MB_C_SHIFT) + (CW'(blk_idx[1]) << BLK_SHIFT);
    w_mvx_int = mvx >>> MB_C_SHIFT;
    w_mvy_int = mvy >>> MB_C_SHIFT;
    ref_x     = w_bx + CW'(w_mvx_int);
    ref_y     = w_by + CW'(w_mvy_int);
    frac_x    = mvx[2:0];
    frac_y    = mvy[2:0];
  end

endmodule
`default_nettype wire

// File: rtl/mc_cr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mc_cr_scheduler
//  Description : Accepts one inter-MB chroma command and issues eight 4x4
//                jobs (Cb0..Cb3, Cr0..Cr3) to the interpolation datapath,
//                limiting in-flight jobs with a credit counter. mb_done
//                pulses once all eight jobs have reported completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_cr_scheduler
  import mc_cr_pkg::*;
#(
  parameter int MBW     = 7,
  parameter int MVW     = 12,
  parameter int CW      = 12,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mb_valid,
  output logic                  mb_ready,
  input  logic        [MBW-1:0] mb_x,
  input  logic        [MBW-1:0] mb_y,
  input  logic signed [MVW-1:0] mvx,
  input  logic signed [MVW-1:0] mvy,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  blk_plane,
  output logic        [1:0]     blk_idx,
  output logic signed [CW-1:0]  ref_x,
  output logic signed [CW-1:0]  ref_y,
  output logic        [2:0]     frac_x,
  output logic        [2:0]     frac_y,
  input  logic                  blk_done,
  output logic                  mb_done,
  output logic                  busy
);

  localparam logic [3:0] c_num_blk = 4'(NUM_BLK);
  localparam logic [3:0] c_last    = 4'(NUM_BLK - 1);
  localparam logic [2:0] c_max_out = 3'(MAX_OUT);

  state_t                r_state;
  state_t                w_next_state;
  logic        [3:0]     r_issue_cnt;
  logic        [3:0]     r_done_cnt;
  logic        [2:0]     r_outstanding;
  logic        [MBW-1:0] r_mb_x;
  logic        [MBW-1:0] r_mb_y;
  logic signed [MVW-1:0] r_mvx;
  logic signed [MVW-1:0] r_mvy;

  logic w_mb_hs;
  logic w_blk_hs;
  logic w_done_ok;

  assign w_mb_hs  = mb_valid && mb_ready;
  assign w_blk_hs = blk_valid && blk_ready;
  // A completion with nothing in flight is a protocol error and is dropped
  assign w_done_ok = blk_done && (r_state != IDLE) && (r_outstanding != 3'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_mb_hs) w_next_state = ISSUE;
      ISSUE:   if (w_blk_hs && (r_issue_cnt == c_last)) w_next_state = DRAIN;
      DRAIN:   if ((r_done_cnt + {3'b000, w_done_ok}) == c_num_blk) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs; a job is offered only while a credit is free
  always_comb begin
    mb_ready  = (r_state == IDLE);
    blk_valid = (r_state == ISSUE) && (r_outstanding < c_max_out);
    mb_done   = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Command capture and job/credit counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt   <= 4'd0;
      r_done_cnt    <= 4'd0;
      r_outstanding <= 3'd0;
      r_mb_x        <= '0;
      r_mb_y        <= '0;
      r_mvx         <= '0;
      r_mvy         <= '0;
    end else if (w_mb_hs) begin
      r_issue_cnt   <= 4'd0;
      r_done_cnt    <= 4'd0;
      r_outstanding <= 3'd0;
      r_mb_x        <= mb_x;
      r_mb_y        <= mb_y;
      r_mvx         <= mvx;
      r_mvy         <= mvy;
    end else begin
      if (w_blk_hs)  r_issue_cnt <= r_issue_cnt + 4'd1;
      if (w_done_ok) r_done_cnt  <= r_done_cnt + 4'd1;
      r_outstanding <= r_outstanding + 3'(w_blk_hs) - 3'(w_done_ok);
    end
  end

  // Job fields come straight from registered state, so they hold while stalled
  assign blk_plane = r_issue_cnt[2] ? PLANE_CR : PLANE_CB;
  assign blk_idx   = r_issue_cnt[1:0];

  mc_cr_addr_gen #(
    .MBW (MBW),
    .MVW (MVW),
    .CW  (CW)
  ) u_addr_gen (
    .mb_x    (r_mb_x),
    .mb_y    (r_mb_y),
    .mvx     (r_mvx),
    .mvy     (r_mvy),
    .blk_idx (r_issue_cnt[1:0]),
    .ref_x   (ref_x),
    .ref_y   (ref_y),
    .frac_x  (frac_x),
    .frac_y  (frac_y)
  );

endmodule
`default_nettype wire
